// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared types and constants for the MIPS memory-access stage:
//            memory-op encodings, FSM state encodings, byte-enable constants
//            and small op-classification helpers.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    LB       = 4'd1,
    LBU      = 4'd2,
    LH       = 4'd3,
    LHU      = 4'd4,
    LW       = 4'd5,
    SB       = 4'd6,
    SH       = 4'd7,
    SW       = 4'd8
  } mem_op_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_t;

  localparam logic [3:0]  BE_NONE    = 4'b0000;
  localparam logic [3:0]  BE_BYTE0   = 4'b0001;
  localparam logic [3:0]  BE_LO_HALF = 4'b0011;
  localparam logic [3:0]  BE_HI_HALF = 4'b1100;
  localparam logic [3:0]  BE_WORD    = 4'b1111;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

  function automatic logic is_load(input logic [3:0] op);
    case (op)
      LB, LBU, LH, LHU, LW: return 1'b1;
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    case (op)
      SB, SH, SW: return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

  // Unknown encodings are not memory ops and flow through like MEM_NONE.
  function automatic logic is_mem(input logic [3:0] op);
    return is_load(op) || is_store(op);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_if
// Purpose  : Bundle of the memory-stage signals: EX/MEM handshake, data-bus
//            request/acknowledge and register-file write port.
//            modport slave  - the memory stage (mem_access)
//            modport master - its environment (pipeline, bus, register file)
// Revision : 1.0 - initial release
// ============================================================================
interface mem_access_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [4:0]  in_dest;
  logic        in_we;
  logic        dbus_req;
  logic        dbus_wr;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic        wb_we;
  logic [4:0]  wb_dest;
  logic [31:0] wb_result;
  logic        bus_err;

  modport slave (
    input  in_valid, in_op, in_addr, in_wdata, in_dest, in_we,
    input  dbus_ack, dbus_rdata,
    output in_ready, dbus_req, dbus_wr, dbus_addr, dbus_be, dbus_wdata,
    output wb_we, wb_dest, wb_result, bus_err
  );

  modport master (
    output in_valid, in_op, in_addr, in_wdata, in_dest, in_we,
    output dbus_ack, dbus_rdata,
    input  in_ready, dbus_req, dbus_wr, dbus_addr, dbus_be, dbus_wdata,
    input  wb_we, wb_dest, wb_result, bus_err
  );
endinterface
`default_nettype wire

// File: rtl/mem_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_align
// Purpose  : Combinational lane logic. From op and addr[1:0] produces store
//            byte enables and lane-replicated store data, the extended load
//            result from read data, and a misalignment flag.
//            Macro MEM_ALIGN_CHECK_EN enables the misalignment flag; when it
//            is undefined the flag is tied to 0.
// Ports    : i_op, i_a, i_wdata, i_rdata -> o_be, o_wdata, o_ldata, o_misalign
// Revision : 1.0 - initial release
// ============================================================================
module mem_align
  import mem_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [1:0]  i_a,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata,
  output logic        o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_a)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    // Halfword lane is chosen by a[1] only; a[0] never shifts the lane.
    w_half = i_a[1] ? i_rdata[31:16] : i_rdata[15:0];

    o_ldata = i_rdata;
    case (i_op)
      LB:      o_ldata = {{24{w_byte[7]}}, w_byte};
      LBU:     o_ldata = {24'd0, w_byte};
      LH:      o_ldata = {{16{w_half[15]}}, w_half};
      LHU:     o_ldata = {16'd0, w_half};
      default: o_ldata = i_rdata;
    endcase

    // Loads and non-memory ops drive no byte enables.
    o_be    = BE_NONE;
    o_wdata = ZERO_WORD;
    case (i_op)
      SB: begin
        o_be    = BE_BYTE0 << i_a;
        o_wdata = {4{i_wdata[7:0]}};
      end
      SH: begin
        o_be    = i_a[1] ? BE_HI_HALF : BE_LO_HALF;
        o_wdata = {2{i_wdata[15:0]}};
      end
      SW: begin
        o_be    = BE_WORD;
        o_wdata = i_wdata;
      end
      default: begin
        o_be    = BE_NONE;
        o_wdata = ZERO_WORD;
      end
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_comb begin
    o_misalign = 1'b0;
    case (i_op)
      LH, LHU, SH: o_misalign = i_a[0];
      LW, SW:      o_misalign = |i_a;
      default:     o_misalign = 1'b0;
    endcase
  end
`else
  assign o_misalign = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module   : mem_access
// Purpose  : MIPS memory-access stage with MEM/WB result register. Accepts
//            one instruction per handshake, performs loads/stores over a
//            request/acknowledge data bus with a timeout, and drives a
//            registered one-cycle register-file write pulse.
//            Macro MEM_ALIGN_CHECK_EN rejects misaligned halfword/word ops
//            with a bus_err pulse instead of issuing them.
// Ports    : clk, rst (async, active-low), mif (mem_access_if.slave)
// Params   : BUS_TIMEOUT - cycles to wait for ack, 0 disables the timeout
// Revision : 1.0 - initial release
// ============================================================================
module mem_access
  import mem_pkg::*;
#(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  mem_access_if.slave   mif
);

  localparam int c_cw = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
  // Counter value at which the wait has lasted BUS_TIMEOUT cycles.
  localparam logic [c_cw-1:0] c_to_last =
    (BUS_TIMEOUT > 0) ? c_cw'(BUS_TIMEOUT - 1) : '0;

  state_t          r_state, w_state_nxt;
  mem_op_t         r_op;
  logic [1:0]      r_a;
  logic [4:0]      r_dest;
  logic            r_we;
  logic [c_cw-1:0] r_cnt;

  logic            r_dbus_wr;
  logic [31:0]     r_dbus_addr;
  logic [3:0]      r_dbus_be;
  logic [31:0]     r_dbus_wdata;
  logic            r_wb_we;
  logic [4:0]      r_wb_dest;
  logic [31:0]     r_wb_result;
  logic            r_bus_err;

  logic            w_accept, w_issue, w_misalign_err, w_complete, w_timeout;
  logic [3:0]      w_op, w_be;
  logic [1:0]      w_a;
  logic [31:0]     w_st_wdata, w_ldata;
  logic            w_misalign;

  // One lane unit serves both phases: in IDLE it steers the incoming
  // request, in BUS it extracts load data for the latched request.
  assign w_op = (r_state == BUS) ? r_op : mif.in_op;
  assign w_a  = (r_state == BUS) ? r_a  : mif.in_addr[1:0];

  mem_align u_align (
    .i_op       (w_op),
    .i_a        (w_a),
    .i_wdata    (mif.in_wdata),
    .i_rdata    (mif.dbus_rdata),
    .o_be       (w_be),
    .o_wdata    (w_st_wdata),
    .o_ldata    (w_ldata),
    .o_misalign (w_misalign)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_accept       = 1'b0;
    w_issue        = 1'b0;
    w_misalign_err = 1'b0;
    w_complete     = 1'b0;
    w_timeout      = 1'b0;
    case (r_state)
      IDLE: begin
        if (mif.in_valid) begin
          w_accept = 1'b1;
          if (is_mem(mif.in_op)) begin
            if (w_misalign) begin
              w_misalign_err = 1'b1;
            end else begin
              w_issue     = 1'b1;
              w_state_nxt = BUS;
            end
          end
        end
      end
      BUS: begin
        if (mif.dbus_ack) begin
          w_complete  = 1'b1;
          w_state_nxt = IDLE;
        end else if ((BUS_TIMEOUT != 0) && (r_cnt == c_to_last)) begin
          w_timeout   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op         <= MEM_NONE;
      r_a          <= 2'd0;
      r_dest       <= 5'd0;
      r_we         <= 1'b0;
      r_cnt        <= '0;
      r_dbus_wr    <= 1'b0;
      r_dbus_addr  <= ZERO_WORD;
      r_dbus_be    <= BE_NONE;
      r_dbus_wdata <= ZERO_WORD;
      r_wb_we      <= 1'b0;
      r_wb_dest    <= 5'd0;
      r_wb_result  <= ZERO_WORD;
      r_bus_err    <= 1'b0;
    end else begin
      r_wb_we   <= 1'b0;
      r_bus_err <= w_timeout || w_misalign_err;

      if (w_accept && !is_mem(mif.in_op)) begin
        r_wb_result <= mif.in_addr;
        r_wb_dest   <= mif.in_dest;
        r_wb_we     <= mif.in_we && (mif.in_dest != 5'd0);
      end

      if (w_issue) begin
        r_op         <= mem_op_t'(mif.in_op);
        r_a          <= mif.in_addr[1:0];
        r_dest       <= mif.in_dest;
        r_we         <= mif.in_we;
        r_cnt        <= '0;
        r_dbus_wr    <= is_store(mif.in_op);
        r_dbus_addr  <= {mif.in_addr[31:2], 2'b00};
        r_dbus_be    <= w_be;
        r_dbus_wdata <= w_st_wdata;
      end else if ((r_state == BUS) && !mif.dbus_ack) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_complete && is_load(r_op)) begin
        r_wb_result <= w_ldata;
        r_wb_dest   <= r_dest;
        r_wb_we     <= r_we && (r_dest != 5'd0);
      end
    end
  end

  assign mif.in_ready   = (r_state == IDLE);
  assign mif.dbus_req   = (r_state == BUS);
  assign mif.dbus_wr    = r_dbus_wr;
  assign mif.dbus_addr  = r_dbus_addr;
  assign mif.dbus_be    = r_dbus_be;
  assign mif.dbus_wdata = r_dbus_wdata;
  assign mif.wb_we      = r_wb_we;
  assign mif.wb_dest    = r_wb_dest;
  assign mif.wb_result  = r_wb_result;
  assign mif.bus_err    = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access
// Purpose  : Directed self-checking bench for mem_access (BUS_TIMEOUT = 4).
//            Expectations follow MEM_ALIGN_CHECK_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mem_access_if ifc ();

  mem_access #(.BUS_TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .mif (ifc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] dest,
                       input logic we);
    ifc.in_valid = 1'b1;
    ifc.in_op    = op;
    ifc.in_addr  = addr;
    ifc.in_wdata = wdata;
    ifc.in_dest  = dest;
    ifc.in_we    = we;
    @(posedge clk);
    @(negedge clk);
    ifc.in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ifc.in_valid   = 1'b0;
    ifc.in_op      = MEM_NONE;
    ifc.in_addr    = 32'd0;
    ifc.in_wdata   = 32'd0;
    ifc.in_dest    = 5'd0;
    ifc.in_we      = 1'b0;
    ifc.dbus_ack   = 1'b0;
    ifc.dbus_rdata = 32'd0;

    // Reset state
    @(negedge clk);
    chk("rst_wb_we",     ifc.wb_we,      0);
    chk("rst_bus_err",   ifc.bus_err,    0);
    chk("rst_req",       ifc.dbus_req,   0);
    chk("rst_be_wr",     {ifc.dbus_be, ifc.dbus_wr}, 0);
    chk("rst_addr",      ifc.dbus_addr,  0);
    chk("rst_wdata",     ifc.dbus_wdata, 0);
    chk("rst_wb_dest",   ifc.wb_dest,    0);
    chk("rst_wb_result", ifc.wb_result,  0);
    rst = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", ifc.in_ready, 1);

    // ALU pass-through
    issue(MEM_NONE, 32'h0000_1234, 32'd0, 5'd5, 1'b1);
    chk("none_we",     ifc.wb_we,     1);
    chk("none_dest",   ifc.wb_dest,   5);
    chk("none_result", ifc.wb_result, 32'h0000_1234);
    @(negedge clk);
    chk("none_pulse",  ifc.wb_we,     0);
    chk("none_hold",   ifc.wb_result, 32'h0000_1234);
    issue(MEM_NONE, 32'h0000_5678, 32'd0, 5'd0, 1'b1);
    chk("none_r0_we",  ifc.wb_we,     0);
    chk("none_r0_res", ifc.wb_result, 32'h0000_5678);

    // LB, ack in the third bus cycle
    issue(LB, 32'h0000_0103, 32'd0, 5'd7, 1'b1);
    chk("lb_req",   ifc.dbus_req,  1);
    chk("lb_addr",  ifc.dbus_addr, 32'h0000_0100);
    chk("lb_be",    ifc.dbus_be,   0);
    chk("lb_wr",    ifc.dbus_wr,   0);
    chk("lb_rdy0",  ifc.in_ready,  0);
    @(negedge clk);
    @(negedge clk);
    chk("lb_rdy2",  ifc.in_ready,  0);
    chk("lb_req2",  ifc.dbus_req,  1);
    ifc.dbus_ack   = 1'b1;
    ifc.dbus_rdata = 32'h80FF_0000;
    @(negedge clk);
    ifc.dbus_ack = 1'b0;
    chk("lb_we",     ifc.wb_we,     1);
    chk("lb_dest",   ifc.wb_dest,   7);
    chk("lb_result", ifc.wb_result, 32'hFFFF_FF80);
    chk("lb_rdy",    ifc.in_ready,  1);
    chk("lb_noreq",  ifc.dbus_req,  0);

    // LBU accepted back-to-back in the writeback cycle, ack immediately
    issue(LBU, 32'h0000_0103, 32'd0, 5'd8, 1'b1);
    chk("lbu_req",   ifc.dbus_req, 1);
    ifc.dbus_ack = 1'b1;
    @(negedge clk);
    ifc.dbus_ack = 1'b0;
    chk("lbu_we",     ifc.wb_we,     1);
    chk("lbu_dest",   ifc.wb_dest,   8);
    chk("lbu_result", ifc.wb_result, 32'h0000_0080);

    // LH upper half, sign-extended
    issue(LH, 32'h0000_0102, 32'd0, 5'd9, 1'b1);
    ifc.dbus_ack   = 1'b1;
    ifc.dbus_rdata = 32'h8001_1234;
    @(negedge clk);
    ifc.dbus_ack = 1'b0;
    chk("lh_result", ifc.wb_result, 32'hFFFF_8001);

    // SH upper lanes
    issue(SH, 32'h0000_0202, 32'hAAAA_BEEF, 5'd3, 1'b0);
    chk("sh_be",    ifc.dbus_be,    4'b1100);
    chk("sh_wdata", ifc.dbus_wdata, 32'hBEEF_BEEF);
    chk("sh_wr",    ifc.dbus_wr,    1);
    chk("sh_addr",  ifc.dbus_addr,  32'h0000_0200);
    @(negedge clk);
    chk("sh_rdy1",  ifc.in_ready,   0);
    ifc.dbus_ack = 1'b1;
    @(negedge clk);
    ifc.dbus_ack = 1'b0;
    chk("sh_rdy",   ifc.in_ready,   1);
    chk("sh_no_we", ifc.wb_we,      0);
    chk("sh_hold",  ifc.wb_result,  32'hFFFF_8001);

    // SB lane 1
    issue(SB, 32'h0000_0001, 32'h1234_565A, 5'd4, 1'b0);
    chk("sb_be",    ifc.dbus_be,    4'b0010);
    chk("sb_wdata", ifc.dbus_wdata, 32'h5A5A_5A5A);
    ifc.dbus_ack = 1'b1;
    @(negedge clk);
    ifc.dbus_ack = 1'b0;
    chk("sb_no_we", ifc.wb_we, 0);

    // Timeout after 4 waiting cycles, late ack ignored
    issue(LW, 32'h0000_0100, 32'd0, 5'd6, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("to_req_wait", ifc.dbus_req, 1);
      chk("to_err_wait", ifc.bus_err,  0);
    end
    @(negedge clk);
    chk("to_err",    ifc.bus_err,  1);
    chk("to_rdy",    ifc.in_ready, 1);
    chk("to_noreq",  ifc.dbus_req, 0);
    chk("to_no_we",  ifc.wb_we,    0);
    ifc.dbus_ack   = 1'b1;
    ifc.dbus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    ifc.dbus_ack = 1'b0;
    chk("late_ack_we",  ifc.wb_we,     0);
    chk("late_ack_err", ifc.bus_err,   0);
    chk("late_ack_res", ifc.wb_result, 32'hFFFF_8001);

    // Asynchronous reset in the middle of a store
    issue(SW, 32'h0000_0300, 32'h1122_3344, 5'd2, 1'b0);
    chk("sw_req", ifc.dbus_req, 1);
    chk("sw_be",  ifc.dbus_be,  4'b1111);
    #2 rst = 1'b0;
    #1;
    chk("arst_req",    ifc.dbus_req,   0);
    chk("arst_be_wr",  {ifc.dbus_be, ifc.dbus_wr}, 0);
    chk("arst_addr",   ifc.dbus_addr,  0);
    chk("arst_wdata",  ifc.dbus_wdata, 0);
    chk("arst_result", ifc.wb_result,  0);
    chk("arst_rdy",    ifc.in_ready,   1);
    @(negedge clk);
    rst = 1'b1;
    ifc.dbus_ack = 1'b1;
    @(negedge clk);
    ifc.dbus_ack = 1'b0;
    chk("arst_ack_we",  ifc.wb_we,    0);
    chk("arst_ack_req", ifc.dbus_req, 0);

    // Misaligned word load
    ifc.dbus_rdata = 32'hCAFE_F00D;
    issue(LW, 32'h0000_0101, 32'd0, 5'd10, 1'b1);
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_noreq", ifc.dbus_req, 0);
    chk("mis_err",   ifc.bus_err,  1);
    chk("mis_rdy",   ifc.in_ready, 1);
    chk("mis_no_we", ifc.wb_we,    0);
    @(negedge clk);
    chk("mis_pulse", ifc.bus_err,  0);
`else
    chk("mis_req",   ifc.dbus_req,  1);
    chk("mis_addr",  ifc.dbus_addr, 32'h0000_0100);
    chk("mis_err",   ifc.bus_err,   0);
    ifc.dbus_ack = 1'b1;
    @(negedge clk);
    ifc.dbus_ack = 1'b0;
    chk("mis_we",     ifc.wb_we,     1);
    chk("mis_result", ifc.wb_result, 32'hCAFE_F00D);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access.md
# mem_access

Memory-access stage plus MEM/WB result register of the five-stage MIPS pipeline. Takes one instruction per accepted handshake from the EX/MEM latch, performs any load/store over a word-wide data-bus request/acknowledge interface, and drives the register-file write port (`wb_we`, `wb_dest`, `wb_result`) with a registered, one-cycle result pulse. While a bus transaction is outstanding it back-pressures upstream through `in_ready`.

## Interface
- `BUS_TIMEOUT`, default 255: maximum cycles `dbus_req` may wait for `dbus_ack`. Value 0 disables the timeout.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: EX/MEM holds a valid instruction.
- `in_ready` out 1: stage accepts an instruction this cycle.
- `in_op` in 4: memory operation encoding, `MEM_NONE`/`LB`/`LBU`/`LH`/`LHU`/`LW`/`SB`/`SH`/`SW`.
- `in_addr` in 32: effective address, or the ALU result for `MEM_NONE`.
- `in_wdata` in 32: store data from the rt register.
- `in_dest` in 5: destination register.
- `in_we` in 1: instruction writes a register.
- `dbus_req` out 1: bus request, held until ack.
- `dbus_wr` out 1: 1 = store.
- `dbus_addr` out 32: word-aligned address, with `[1:0]` forced to 0.
- `dbus_be` out 4: byte enables, bit i is byte lane i, little-endian.
- `dbus_wdata` out 32: lane-steered store data.
- `dbus_ack` in 1: transaction complete; `dbus_rdata` is valid in the same cycle.
- `dbus_rdata` in 32: read data.
- `wb_we` out 1: register-file write enable, a one-cycle pulse.
- `wb_dest` out 5: write address.
- `wb_result` out 32: write data.
- `bus_err` out 1: one-cycle pulse on timeout or misalignment.

## Operation
- **FSM states:** `IDLE`, `BUS`.
- **`in_ready` rule:** `in_ready = (state == IDLE)`. Acceptance happens when `in_valid && in_ready` is sampled at the edge.
- **`MEM_NONE` accepted:**
  - Next edge: `wb_result <= in_addr`, `wb_dest <= in_dest`, `wb_we <= in_we && (in_dest != 0)`.
  - State stays `IDLE`.
- **Load or store accepted:**
  - Latch op, addr, wdata, dest and we; state goes to `BUS`.
  - `dbus_*` outputs come from the latched request and stay stable throughout `BUS`.
- **In `BUS`:**
  - `dbus_req = 1`. A timeout counter is cleared on entry and increments each cycle without ack.
- **`dbus_ack` in `BUS`:**
  - Next edge: state returns to `IDLE`.
  - For a load, `wb_we` pulses with the extended data.
  - For a store, `wb_we` stays 0.
- **Load extraction:**
  - Byte = `rdata[8*a+7:8*a]`; halfword = `rdata[16*a1+15:16*a1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
- **Store steering:**
  - SB: `be = 1<<a`, byte replicated to all 4 lanes.
  - SH: `be = a1 ? 4'b1100 : 4'b0011`, half replicated.
  - SW: `be = 4'b1111`.
- **Timeout:**
  - When the counter reaches `BUS_TIMEOUT` (nonzero) without ack: return to `IDLE`, pulse `bus_err`, no writeback.
- **Ack outside `BUS`:** ignored.
- **`wb_we` default:** when no completion occurs in a cycle, `wb_we` is 0 next cycle. `wb_dest`/`wb_result` hold their last values.

## Timing
- **Reset values (asynchronous):**
  - State `IDLE`; counter 0.
  - `wb_we`, `bus_err`, `dbus_req`, `dbus_wr`, `dbus_be` = 0; `wb_dest` = 0; `wb_result` = 0; `dbus_addr`/`dbus_wdata` = 0.
  - `in_ready` is 1 from the first edge after deassertion.
- **Reset mid-`BUS`:** `dbus_req` drops immediately (asynchronous). The transaction is abandoned with no writeback; a later ack is ignored.
- **`MEM_NONE` latency:** 1 cycle, accept edge to `wb_we`. Throughput is 1 per cycle.
- **Memory op latency:**
  - Accept at edge T; `dbus_req` is high from T.
  - Ack in cycle T+k (k ≥ 0 cycles after entry); `wb_we` is high in the cycle after the ack edge.
  - Minimum 2 cycles accept-to-writeback; `in_ready` is low for k+1 cycles.
- **Back-to-back:** a new instruction may be accepted in the cycle `wb_we` is high. The register file forwards `wb_result` internally.

## Configuration
- **`MEM_ALIGN_CHECK_EN` defined:**
  - LH/LHU/SH with `addr[0]`, or LW/SW with `addr[1:0] != 0`, is accepted but issues no bus request.
  - `bus_err` pulses on the next edge, `wb_we` = 0, and state stays `IDLE`.
- **Not defined:**
  - Halfword uses `a1` only and ignores `addr[0]`; word ignores `addr[1:0]`.
  - `bus_err` comes only from timeout.

## Structure
- **Shared package `mem_pkg`:** `mem_op_t` enum/localparams; `IDLE`/`BUS` state encodings; `BE_*` byte-enable constants; `ZERO_WORD`.
- **Sub-module `mem_align`:** purely combinational; op + `addr[1:0]` + wdata/rdata → be, steered wdata, extended load data, misalign flag. The FSM, timeout counter and WB register live in `mem_access`.

## Test plan
- **ALU pass-through:** `MEM_NONE`, addr=0x1234, dest=5, we=1 → next cycle `wb_we`=1, `wb_dest`=5, `wb_result`=0x00001234. Repeat with dest=0 → `wb_we`=0.
- **LB sign-extend:** LB addr=0x103, ack after 3 cycles with rdata=0x80FF_0000 → `dbus_addr`=0x100, `be`=0; `wb_result`=0xFFFFFF80. LBU on the same data → 0x00000080.
- **SH lanes:** SH addr=0x202, wdata=0xAAAA_BEEF → `be`=4'b1100, `dbus_wdata`=0xBEEF_BEEF, `dbus_wr`=1, no `wb_we`. `in_ready` low until the edge after ack.
- **Timeout:** `BUS_TIMEOUT`=4, LW with no ack → `bus_err` pulse after 4 waiting cycles, `wb_we`=0, `in_ready` returns to 1. A late ack is ignored.
- **Async reset mid-`BUS`:** assert `rst`=0 while `dbus_req`=1 → `dbus_req` goes 0 before the next edge and all outputs take their reset values.
- **Misaligned word:** LW addr=0x101 → with `MEM_ALIGN_CHECK_EN`: no `dbus_req`, `bus_err` pulse. Without it: `dbus_addr`=0x100, normal load.
